// File: rtl/sram_array_1r1w_ext_pkg.sv
// Shared types and helpers for the 1R1W SRAM array block.
// Holds the clear-FSM state encoding and the address-width helper.
package sram_array_1r1w_ext_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sram_array_1r1w_ext_if.sv
// Request/response bundle for the 1R1W SRAM array.
// The master drives requests; the slave returns read data and ready.
interface sram_array_1r1w_ext_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 6,
  parameter int MASK_W = 2
);

  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [DATA_W-1:0] R0_rdata;
  logic              R0_valid;
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [MASK_W-1:0] W0_mask;
  logic [DATA_W-1:0] W0_wdata;
  logic              init_req;
  logic              ready;

  modport master (
    output R0_en, R0_addr,
    output W0_en, W0_addr, W0_mask, W0_wdata,
    output init_req,
    input  R0_rdata, R0_valid, ready
  );

  modport slave (
    input  R0_en, R0_addr,
    input  W0_en, W0_addr, W0_mask, W0_wdata,
    input  init_req,
    output R0_rdata, R0_valid, ready
  );

endinterface

// File: rtl/sram_array_1r1w_ext_init_ctrl.sv
// Clear controller: walks every word to zero, then opens the array.
// INIT lasts exactly DEPTH cycles; init_req restarts it from READY.
module sram_init_ctrl
  import sram_array_1r1w_ext_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = 6,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              ready,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam state_e RST_ST = INIT_ON_RESET ? ST_INIT : ST_READY;

  state_e          state;
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST_ST;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST) begin
            state <= ST_READY;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (init_req) begin
            state <= ST_INIT;
            ready <= 1'b0;
            cnt   <= '0;
          end else begin
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign clr_en   = (state == ST_INIT);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/sram_array_1r1w_ext.sv
// Masked 1R1W SRAM array with optional write-to-read bypass.
// Storage has no reset; it is zeroed by the clear controller.
module sram_array_1r1w_ext
  import sram_array_1r1w_ext_pkg::*;
#(
  parameter int DATA_W        = 20,
  parameter int DEPTH         = 64,
  parameter int MASK_W        = 2,
  parameter bit BYPASS        = 1'b1,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic                  clock,
  input logic                  reset_n,
  sram_array_1r1w_ext_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int LANE_W = DATA_W / MASK_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  sram_init_ctrl #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .INIT_ON_RESET(INIT_ON_RESET)
  ) u_ctrl (
    .clock   (clock),
    .reset_n (reset_n),
    .init_req(bus.init_req),
    .ready   (ready),
    .clr_en  (clr_en),
    .clr_addr(clr_addr)
  );

  assign bus.ready = ready;

  logic              wr_ok;
  logic              rd_ok;
  logic              rd_in;
  logic [DATA_W-1:0] bitmask;
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;

  assign rd_in = ({1'b0, bus.R0_addr} < DEPTH_V);
  assign wr_ok = bus.W0_en & ready &
                 ({1'b0, bus.W0_addr} < DEPTH_V);
  assign rd_ok = bus.R0_en & ready;

  always_comb begin
    bitmask = '0;
    for (int i = 0; i < MASK_W; i++) begin
      bitmask[i*LANE_W +: LANE_W] = {LANE_W{bus.W0_mask[i]}};
    end
  end

  assign old_w  = mem[bus.W0_addr];
  assign merged = (old_w & ~bitmask) | (bus.W0_wdata & bitmask);

  // Bypass forwards the lane-merged word, not raw wdata.
  always_comb begin
    rd_word = mem[bus.R0_addr];
    if (!rd_in) begin
      rd_word = '0;
    end else if (BYPASS && wr_ok &&
                 bus.W0_addr == bus.R0_addr) begin
      rd_word = merged;
    end
  end

  always_ff @(posedge clock) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[bus.W0_addr] <= merged;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.R0_valid <= 1'b0;
      bus.R0_rdata <= '0;
    end else begin
      bus.R0_valid <= rd_ok;
      if (rd_ok) begin
        bus.R0_rdata <= rd_word;
      end
    end
  end

endmodule

// File: doc/sram_array_1r1w_ext.md
SRAM_ARRAY_1R1W_EXT -- requirements
Module: sram_array_1r1w_ext

Interface
REQ-001 Parameter DATA_W, default 20, memory word width in bits.
REQ-002 Parameter DEPTH, default 64, number of words; any value of 2 or more, not restricted to powers of two.
REQ-003 Parameter MASK_W, default 2, number of write-mask lanes; DATA_W SHALL be a multiple of MASK_W; lane width LANE_W = DATA_W/MASK_W.
REQ-004 Parameter BYPASS, default 1, 1 = a same-cycle same-address read returns the newly written data.
REQ-005 Parameter INIT_ON_RESET, default 1, 1 = memory is cleared to zero after every reset release.
REQ-006 Derived ADDR_W = clog2(DEPTH), minimum 1.
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 R0_en  in  1  read request.
REQ-010 R0_addr  in  ADDR_W  read address.
REQ-011 R0_rdata  out  DATA_W  read data.
REQ-012 R0_valid  out  1  R0_rdata holds the result of the read accepted in the previous cycle.
REQ-013 W0_en  in  1  write request.
REQ-014 W0_addr  in  ADDR_W  write address.
REQ-015 W0_mask  in  MASK_W  per-lane write enable; bit i covers data bits [i*LANE_W +: LANE_W].
REQ-016 W0_wdata  in  DATA_W  write data.
REQ-017 init_req  in  1  single-cycle pulse that starts a memory clear.
REQ-018 ready  out  1  block is accepting requests.

Function
REQ-019 The FSM SHALL have states INIT and READY.
REQ-020 On reset release, the FSM SHALL enter INIT when INIT_ON_RESET=1, and READY otherwise.
REQ-021 In INIT, the block SHALL write zero to one address per cycle, from 0 to DEPTH-1, using an ADDR_W+1-bit counter.
REQ-022 In INIT, the FSM SHALL move to READY on the cycle after address DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
REQ-023 In READY, init_req=1 SHALL move the FSM to INIT with the counter set to 0.
REQ-024 In INIT, init_req SHALL be ignored.
REQ-025 ready SHALL be 1 only in the READY state.
REQ-026 While ready=0, R0_en and W0_en SHALL be ignored: no array update and no R0_valid pulse.
REQ-027 A write is accepted when W0_en=1 and ready=1.
REQ-028 On the next clock edge, each lane with W0_mask[i]=1 SHALL be updated and lanes with W0_mask[i]=0 SHALL keep their value.
REQ-029 A write with W0_mask=0 SHALL be a no-op.
REQ-030 A read is accepted when R0_en=1 and ready=1.
REQ-031 Read latency SHALL be 1: R0_valid=1 and R0_rdata=word in the cycle after acceptance.
REQ-032 With no accepted read, R0_valid SHALL be 0 and R0_rdata SHALL hold its last value.
REQ-033 Same-cycle read and write to the same address with BYPASS=1: R0_rdata SHALL return the lane-merged result (masked lanes from W0_wdata, other lanes from the old word).
REQ-034 Same-cycle read and write to the same address with BYPASS=0: R0_rdata SHALL return the old word.
REQ-035 Reads and writes to different addresses in the same cycle SHALL be fully independent.
REQ-036 An address of DEPTH or above: writes SHALL be ignored, and reads SHALL return zero with R0_valid=1.
REQ-037 A read accepted on the last INIT cycle cannot occur (ready=0).
REQ-038 The first read accepted in READY SHALL return zero for every address.
REQ-039 Array contents SHALL never be X after INIT completes.

Reset
REQ-040 reset_n=0 SHALL asynchronously force: state INIT (or READY when INIT_ON_RESET=0), counter 0, ready 0, R0_valid 0, R0_rdata 0.
REQ-041 Array storage SHALL have no reset; it is cleared only by INIT.
REQ-042 Reset asserted mid-INIT SHALL restart the clear from address 0 after release.

Structure
REQ-043 A shared package SHALL hold the FSM state enum (INIT, READY) and the clog2 helper function.
REQ-044 One sub-module, sram_init_ctrl, SHALL hold the FSM, the counter and ready, and drive the clear write port.
REQ-045 The array and bypass logic SHALL stay in the top module.

Verification
REQ-046 Defaults, reset release, no requests -> ready=0 for exactly 64 cycles then 1; reading addresses 0..63 returns 0x00000 each.
REQ-047 Write addr 5, data 0xABCDE, mask 2'b01, then read 5 -> 0x000DE (upper lane 0x000 from init) with R0_valid one cycle after R0_en.
REQ-048 Same cycle: write addr 9, data 0x12345, mask 2'b11 and read addr 9 -> 0x12345 when BYPASS=1; 0x00000 when BYPASS=0.
REQ-049 Write addr 3 = 0xFFFFF, pulse init_req, issue R0_en/W0_en during INIT -> no R0_valid; after 64 cycles, addr 3 reads 0x00000.
REQ-050 DEPTH=48: reset_n asserted at INIT cycle 20 for 2 cycles -> ready rises 48 cycles after release; write addr 50 is ignored; read addr 50 returns 0 with R0_valid=1.
